// File: rtl/bitsum_argmin_pkg.sv
// Shared constants for the correlator argmin stage.
// Default search geometry and mismatch-count width used at instantiation.
// Imported by the argmin top level.
package bitsum_argmin_pkg;

  localparam int SUM_W        = 8;   // width of a bitsum mismatch count
  localparam int SEARCH_POS   = 32;  // candidate offsets per search
  localparam int SEARCH_POS_W = 5;   // index width for SEARCH_POS offsets

endpackage

// File: rtl/bitsum_argmin_min2_update.sv
// Combinational two-smallest tracker: folds one new value into (best, second).
// Latency 0 (pure combinational); no handshake, caller decides when to commit.
// Strict compares: an equal-to-best value lands in second, keeping the earliest best.
module bitsum_argmin_min2_update #(
  parameter int W = 8
) (
  input  logic [W-1:0] sum_i,
  input  logic [W-1:0] best_i,
  input  logic [W-1:0] second_i,
  output logic [W-1:0] new_best_o,
  output logic [W-1:0] new_second_o,
  output logic         take_best_o
);

  // New minimum demotes the old best to second; otherwise it may only replace second.
  always_comb begin
    new_best_o   = best_i;
    new_second_o = second_i;
    take_best_o  = 1'b0;
    if (sum_i < best_i) begin
      new_best_o   = sum_i;
      new_second_o = best_i;
      take_best_o  = 1'b1;
    end else if (sum_i < second_i) begin
      new_second_o = sum_i;
    end
  end

endmodule

// File: rtl/bitsum_argmin.sv
// Streaming argmin over NUM_POS mismatch counts: best count, its offset and runner-up.
// Latency: result valid 1 clk after the last sample is accepted.
// Result held stable until res_ready; start aborts any search or pending result.
module bitsum_argmin
  import bitsum_argmin_pkg::*;
#(
  parameter int NUM_POS = SEARCH_POS,
  parameter int POS_W   = SEARCH_POS_W,
  parameter int SUM_W   = bitsum_argmin_pkg::SUM_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sum_valid,
  input  logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] best_sum,
  output logic [POS_W-1:0] best_pos,
  output logic [SUM_W-1:0] second_sum,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);

  state_t           state_q;
  logic [POS_W-1:0] cnt_q;
  logic [SUM_W-1:0] best_q;
  logic [SUM_W-1:0] second_q;
  logic [POS_W-1:0] pos_q;
  logic             busy_q;
  logic             res_valid_q;
  logic             overrun_q;

  logic [SUM_W-1:0] best_d;
  logic [SUM_W-1:0] second_d;
  logic             take_best_d;

  bitsum_argmin_min2_update #(
    .W(SUM_W)
  ) u_min2 (
    .sum_i       (sum),
    .best_i      (best_q),
    .second_i    (second_q),
    .new_best_o  (best_d),
    .new_second_o(second_d),
    .take_best_o (take_best_d)
  );

  // Search control; start overrides every other input on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      best_q      <= '1;
      second_q    <= '1;
      pos_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (start) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      best_q      <= '1;
      second_q    <= '1;
      pos_q       <= '0;
      busy_q      <= 1'b1;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sum_valid) overrun_q <= 1'b1;
        end
        ST_ACCUM: begin
          if (sum_valid) begin
            best_q   <= best_d;
            second_q <= second_d;
            if (take_best_d) pos_q <= cnt_q;
            // Leaving on the last offset keeps the counter from ever wrapping.
            if (cnt_q == LAST_POS) begin
              state_q     <= ST_RESULT;
              busy_q      <= 1'b0;
              res_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + POS_W'(1);
            end
          end
        end
        ST_RESULT: begin
          if (sum_valid) overrun_q <= 1'b1;
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign best_sum   = best_q;
  assign best_pos   = pos_q;
  assign second_sum = second_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_bitsum_argmin.sv
// Randomised bench for bitsum_argmin with a queue-based scoreboard.
// Stimulus drives on the falling edge; the monitor samples just after it.
// Expected results come from a list-level min / runner-up model.
module tb_bitsum_argmin;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       sum_valid;
  logic [7:0] sum;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] best_sum;
  logic [4:0] best_pos;
  logic [7:0] second_sum;
  logic       overrun;

  bitsum_argmin dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .sum_valid (sum_valid),
    .sum       (sum),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .best_sum  (best_sum),
    .best_pos  (best_pos),
    .second_sum(second_sum),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int best;
    int pos;
    int second;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Minimum with earliest index, then smallest of the remaining entries.
  function automatic exp_t model(input int s[$]);
    exp_t e;
    e.best   = 256;
    e.pos    = 0;
    e.second = 256;
    foreach (s[i]) if (s[i] < e.best) begin
      e.best = s[i];
      e.pos  = i;
    end
    foreach (s[i]) if (i != e.pos && s[i] < e.second) e.second = s[i];
    return e;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int v, input int gap);
    sum_valid = 1'b1;
    sum       = 8'(v);
    @(negedge clk);
    sum_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // One full search; the expected result is queued before the samples go out.
  task automatic run(input int s[$], input int maxgap, input bit with_start);
    if (with_start) do_start();
    exp_q.push_back(model(s));
    foreach (s[i]) send(s[i], (i == s.size() - 1 || maxgap == 0) ? 0 : int'($urandom_range(1, maxgap)));
    chk("latency_res_valid", int'(res_valid), 1);
    chk("busy_after_last", int'(busy), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_best_sum"}, int'(best_sum), 255);
    chk({tag, "_second_sum"}, int'(second_sum), 255);
    chk({tag, "_best_pos"}, int'(best_pos), 0);
  endtask

  // Monitor: pops on each handshake and checks outputs hold while stalled.
  initial begin : monitor
    bit       prev_hold = 1'b0;
    int       pb = 0, pp = 0, ps = 0;
    exp_t     e;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_res_valid", int'(res_valid), 1);
          chk("hold_best_sum", int'(best_sum), pb);
          chk("hold_best_pos", int'(best_pos), pp);
          chk("hold_second_sum", int'(second_sum), ps);
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("best_sum", int'(best_sum), e.best);
            chk("best_pos", int'(best_pos), e.pos);
            chk("second_sum", int'(second_sum), e.second);
            chk("overrun_at_result", int'(overrun), 0);
          end
        end
        prev_hold = res_valid && !res_ready;
        pb = int'(best_sum);
        pp = int'(best_pos);
        ps = int'(second_sum);
      end
    end
  end

  initial begin : stim
    int s[$];
    int ties[$];
    resetn    = 1'b0;
    start     = 1'b0;
    sum_valid = 1'b0;
    sum       = 8'd0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Descending stream: minimum at the last offset.
    s.delete();
    for (int i = 0; i < 32; i++) s.push_back(40 - i);
    run(s, 0, 1'b1);
    @(negedge clk);
    chk("desc_rv_drop", int'(res_valid), 0);

    // Tied minimum: earliest index wins, the tie lands in second.
    ties.delete();
    for (int i = 0; i < 32; i++) ties.push_back((i == 7 || i == 20) ? 12 : 50);
    run(ties, 0, 1'b1);
    @(negedge clk);

    // Same stream with gaps and a stalled consumer.
    res_ready = 1'b0;
    run(ties, 3, 1'b1);
    repeat (10) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall_rv_drop", int'(res_valid), 0);
    chk("stall_busy_idle", int'(busy), 0);

    // Abort after 10 samples; a zero coincident with the restart must be dropped.
    do_start();
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 255)), 0);
    start     = 1'b1;
    sum_valid = 1'b1;
    sum       = 8'd0;
    @(negedge clk);
    start     = 1'b0;
    sum_valid = 1'b0;
    chk("restart_busy", int'(busy), 1);
    s.delete();
    for (int i = 0; i < 32; i++) s.push_back((i == 4) ? 3 : int'($urandom_range(10, 255)));
    run(s, 0, 1'b0);
    @(negedge clk);

    // Stray sample in IDLE sets overrun; start clears it.
    send(77, 0);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_no_result", int'(res_valid), 0);
    do_start();
    chk("overrun_cleared", int'(overrun), 0);
    s.delete();
    for (int i = 0; i < 32; i++) s.push_back(int'($urandom_range(0, 255)));
    run(s, 0, 1'b0);
    @(negedge clk);

    // Asynchronous reset in the middle of a search.
    do_start();
    for (int i = 0; i < 15; i++) send(int'($urandom_range(0, 100)), 0);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_no_result", int'(res_valid), 0);
    end

    // Fresh random searches, with and without gaps.
    for (int k = 0; k < 4; k++) begin
      s.delete();
      for (int i = 0; i < 32; i++) s.push_back(int'($urandom_range(0, 255)));
      run(s, (k % 2) * 3, 1'b1);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
